// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Hazard unit for the brisc five-stage core (F, D, EX, C, WB). Drives the
//   forward selects for the two EX operands, every stage stall and flush, a
//   multi-cycle multiply sequencer and a saturating stall-cycle counter.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   rs1_D_in, rs2_D_in         D-stage source indices
//   rs1_used_D_in/rs2_used_D_in D instruction really reads that source
//   rs1_EX_in, rs2_EX_in       EX-stage source indices
//   rd_EX_in                   EX-stage destination index
//   is_mul_EX_in               EX instruction is a multiply
//   result_src_EX_in           FROM_CACHE marks a load in EX
//   rd_C_in, reg_write_C_in    C-stage destination and write enable
//   rd_WB_in, reg_write_WB_in  WB-stage destination and write enable
//   pc_src_in                  FROM_EX marks a taken branch/jump in EX
//   mem_stall_in               cache miss pending in C
//   fwd_src1_out, fwd_src2_out EX operand forward selects
//   stall_*_out, flush_*_out   per-stage stall and flush controls
//   mul_busy_out               multiply sequencer is in BUSY
//   stall_cycles_out           saturating count of cycles with stall_F_out=1

package hazard_unit_mc_pkg;
  typedef enum logic [1:0] {FROM_ALU = 2'd0, FROM_CACHE = 2'd1, FROM_LINK = 2'd2} result_src_e;
  typedef enum logic {FROM_PLUS4 = 1'b0, FROM_EX = 1'b1} pc_src_e;
  typedef enum logic [1:0] {NONE = 2'd0, FROM_C = 2'd1, FROM_WB = 2'd2} fwd_src_e;
endpackage

module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_BITS  = 5,
  parameter int MUL_LAT   = 4,
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_BITS-1:0]  rs1_D_in,
  input  logic [REG_BITS-1:0]  rs2_D_in,
  input  logic                 rs1_used_D_in,
  input  logic                 rs2_used_D_in,
  input  logic [REG_BITS-1:0]  rs1_EX_in,
  input  logic [REG_BITS-1:0]  rs2_EX_in,
  input  logic [REG_BITS-1:0]  rd_EX_in,
  input  logic                 is_mul_EX_in,
  input  result_src_e          result_src_EX_in,
  input  logic [REG_BITS-1:0]  rd_C_in,
  input  logic [REG_BITS-1:0]  rd_WB_in,
  input  logic                 reg_write_C_in,
  input  logic                 reg_write_WB_in,
  input  pc_src_e              pc_src_in,
  input  logic                 mem_stall_in,
  output fwd_src_e             fwd_src1_out,
  output fwd_src_e             fwd_src2_out,
  output logic                 stall_F_out,
  output logic                 stall_D_out,
  output logic                 stall_EX_out,
  output logic                 stall_C_out,
  output logic                 flush_D_out,
  output logic                 flush_EX_out,
  output logic                 flush_C_out,
  output logic                 flush_WB_out,
  output logic                 mul_busy_out,
  output logic [PERF_BITS-1:0] stall_cycles_out
);

  localparam int CNT_W = $clog2(MUL_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_e;

  mul_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             mc;
  logic             lu;

  // C has priority over WB because it holds the younger result; x0 is never forwarded.
  function automatic fwd_src_e fwd_sel(input logic [REG_BITS-1:0] rs);
    if (rs != '0 && reg_write_C_in && rs == rd_C_in)
      return FROM_C;
    else if (rs != '0 && reg_write_WB_in && rs == rd_WB_in)
      return FROM_WB;
    else
      return NONE;
  endfunction

  always_comb begin
    fwd_src1_out = fwd_sel(rs1_EX_in);
    fwd_src2_out = fwd_sel(rs2_EX_in);
  end

  always_comb begin
    lu = (result_src_EX_in == FROM_CACHE) && (rd_EX_in != '0) &&
         ((rs1_used_D_in && rs1_D_in == rd_EX_in) ||
          (rs2_used_D_in && rs2_D_in == rd_EX_in));
  end

  // The multiply holds EX on its first cycle (while still IDLE) and on every
  // BUSY cycle except the last, giving MUL_LAT-1 stalled cycles in total.
  always_comb begin
    mc = 1'b0;
    if (state == IDLE)
      mc = is_mul_EX_in && (MUL_LAT > 1) && !mem_stall_in;
    else
      mc = (cnt != CNT_LAST);
  end

  // A cache miss freezes everything, so the branch stays in EX and its
  // flush is re-issued once the miss releases.
  always_comb begin
    stall_F_out  = 1'b0;
    stall_D_out  = 1'b0;
    stall_EX_out = 1'b0;
    stall_C_out  = 1'b0;
    flush_D_out  = 1'b0;
    flush_EX_out = 1'b0;
    flush_C_out  = 1'b0;
    flush_WB_out = 1'b0;
    if (mem_stall_in) begin
      stall_F_out  = 1'b1;
      stall_D_out  = 1'b1;
      stall_EX_out = 1'b1;
      stall_C_out  = 1'b1;
      flush_WB_out = 1'b1;
    end else if (mc) begin
      stall_F_out  = 1'b1;
      stall_D_out  = 1'b1;
      stall_EX_out = 1'b1;
      flush_C_out  = 1'b1;
    end else if (lu) begin
      stall_F_out  = 1'b1;
      stall_D_out  = 1'b1;
      flush_EX_out = 1'b1;
    end else if (pc_src_in == FROM_EX) begin
      flush_D_out  = 1'b1;
      flush_EX_out = 1'b1;
    end
  end

  // Multiply sequencer; a pending cache miss holds both state and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!mem_stall_in) begin
      case (state)
        IDLE: begin
          if (mc) begin
            state <= BUSY;
            cnt   <= CNT_W'(1);
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign mul_busy_out = (state == BUSY);

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles_out <= '0;
    else if (stall_F_out && stall_cycles_out != {PERF_BITS{1'b1}})
      stall_cycles_out <= stall_cycles_out + PERF_BITS'(1);
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc
//   Directed bench for hazard_unit_mc. A main instance (MUL_LAT=4, 32-bit
//   counter) and a small instance (MUL_LAT=1, 4-bit counter) share stimulus.
//   Control outputs are packed as {SF,SD,SE,SC,FD,FE,FC,FW}.

module tb_hazard_unit_mc;
  import hazard_unit_mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_D, rs2_D, rs1_EX, rs2_EX, rd_EX, rd_C, rd_WB;
  logic        rs1_used_D, rs2_used_D, is_mul_EX, reg_write_C, reg_write_WB, mem_stall;
  result_src_e result_src_EX;
  pc_src_e     pc_src;

  fwd_src_e    fwd1, fwd2, fwd1_s, fwd2_s;
  logic        sf, sd, se, sc, fd, fe, fc, fw, busy;
  logic        sf_s, sd_s, se_s, sc_s, fd_s, fe_s, fc_s, fw_s, busy_s;
  logic [31:0] cycles;
  logic [3:0]  cycles_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_BITS(5), .MUL_LAT(4), .PERF_BITS(32)) dut (
    .clk(clk), .reset(reset),
    .rs1_D_in(rs1_D), .rs2_D_in(rs2_D), .rs1_used_D_in(rs1_used_D), .rs2_used_D_in(rs2_used_D),
    .rs1_EX_in(rs1_EX), .rs2_EX_in(rs2_EX), .rd_EX_in(rd_EX), .is_mul_EX_in(is_mul_EX),
    .result_src_EX_in(result_src_EX), .rd_C_in(rd_C), .rd_WB_in(rd_WB),
    .reg_write_C_in(reg_write_C), .reg_write_WB_in(reg_write_WB), .pc_src_in(pc_src),
    .mem_stall_in(mem_stall), .fwd_src1_out(fwd1), .fwd_src2_out(fwd2),
    .stall_F_out(sf), .stall_D_out(sd), .stall_EX_out(se), .stall_C_out(sc),
    .flush_D_out(fd), .flush_EX_out(fe), .flush_C_out(fc), .flush_WB_out(fw),
    .mul_busy_out(busy), .stall_cycles_out(cycles)
  );

  hazard_unit_mc #(.REG_BITS(5), .MUL_LAT(1), .PERF_BITS(4)) dut_small (
    .clk(clk), .reset(reset),
    .rs1_D_in(rs1_D), .rs2_D_in(rs2_D), .rs1_used_D_in(rs1_used_D), .rs2_used_D_in(rs2_used_D),
    .rs1_EX_in(rs1_EX), .rs2_EX_in(rs2_EX), .rd_EX_in(rd_EX), .is_mul_EX_in(is_mul_EX),
    .result_src_EX_in(result_src_EX), .rd_C_in(rd_C), .rd_WB_in(rd_WB),
    .reg_write_C_in(reg_write_C), .reg_write_WB_in(reg_write_WB), .pc_src_in(pc_src),
    .mem_stall_in(mem_stall), .fwd_src1_out(fwd1_s), .fwd_src2_out(fwd2_s),
    .stall_F_out(sf_s), .stall_D_out(sd_s), .stall_EX_out(se_s), .stall_C_out(sc_s),
    .flush_D_out(fd_s), .flush_EX_out(fe_s), .flush_C_out(fc_s), .flush_WB_out(fw_s),
    .mul_busy_out(busy_s), .stall_cycles_out(cycles_s)
  );

  function automatic logic [7:0] ctl();
    return {sf, sd, se, sc, fd, fe, fc, fw};
  endfunction

  // Advance one clock, leaving time just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_D = '0; rs2_D = '0; rs1_used_D = 1'b0; rs2_used_D = 1'b0;
    rs1_EX = '0; rs2_EX = '0; rd_EX = '0; rd_C = '0; rd_WB = '0;
    is_mul_EX = 1'b0; reg_write_C = 1'b0; reg_write_WB = 1'b0; mem_stall = 1'b0;
    result_src_EX = FROM_ALU; pc_src = FROM_PLUS4;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (ctl() !== 8'b0000_0000) begin
      n_err++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl(), 8'b0);
    end
    n_vec++;
    if ({busy, cycles} !== 33'd0 || fwd1 !== NONE || fwd2 !== NONE) begin
      n_err++; $display("[TB] FAIL reset_state: busy=%0d cycles=%0d fwd1=%0d fwd2=%0d expected 0/0/NONE/NONE", busy, cycles, fwd1, fwd2);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    rs1_EX = 5'd5; rd_C = 5'd5; reg_write_C = 1'b1; rd_WB = 5'd5; reg_write_WB = 1'b1;
    #1;
    n_vec++;
    if (fwd1 !== FROM_C) begin
      n_err++; $display("[TB] FAIL fwd_c_priority: got %0d expected %0d", fwd1, FROM_C);
    end
    reg_write_C = 1'b0; rs2_EX = 5'd5;
    #1;
    n_vec++;
    if (fwd1 !== FROM_WB || fwd2 !== FROM_WB) begin
      n_err++; $display("[TB] FAIL fwd_wb: got %0d/%0d expected %0d/%0d", fwd1, fwd2, FROM_WB, FROM_WB);
    end
    rs1_EX = 5'd0; rd_C = 5'd0; reg_write_C = 1'b1; rs2_EX = 5'd9;
    #1;
    n_vec++;
    if (fwd1 !== NONE || fwd2 !== NONE) begin
      n_err++; $display("[TB] FAIL fwd_x0_none: got %0d/%0d expected %0d/%0d", fwd1, fwd2, NONE, NONE);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    result_src_EX = FROM_CACHE; rd_EX = 5'd3; rs2_D = 5'd3; rs2_used_D = 1'b1;
    #1;
    n_vec++;
    if (ctl() !== 8'b1100_0100) begin
      n_err++; $display("[TB] FAIL load_use: got %b expected %b", ctl(), 8'b1100_0100);
    end
    rs2_used_D = 1'b0; rs1_D = 5'd3;
    #1;
    n_vec++;
    if (ctl() !== 8'b0000_0000) begin
      n_err++; $display("[TB] FAIL load_use_unused: got %b expected %b", ctl(), 8'b0);
    end
    rd_EX = 5'd0; rs1_D = 5'd0; rs1_used_D = 1'b1;
    #1;
    n_vec++;
    if (ctl() !== 8'b0000_0000) begin
      n_err++; $display("[TB] FAIL load_use_x0: got %b expected %b", ctl(), 8'b0);
    end
    result_src_EX = FROM_ALU; pc_src = FROM_EX;
    #1;
    n_vec++;
    if (ctl() !== 8'b0000_1100) begin
      n_err++; $display("[TB] FAIL branch_flush: got %b expected %b", ctl(), 8'b0000_1100);
    end
  endtask

  task automatic test_multiply();
    logic [7:0] exp_ctl [4] = '{8'b1110_0010, 8'b1110_0010, 8'b1110_0010, 8'b0000_0000};
    logic       exp_busy [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    is_mul_EX = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        result_src_EX = FROM_CACHE; rd_EX = 5'd4; rs1_D = 5'd4; rs1_used_D = 1'b1;
      end
      if (i == 2) begin
        result_src_EX = FROM_ALU;
      end
      #1;
      n_vec++;
      if (ctl() !== exp_ctl[i] || busy !== exp_busy[i]) begin
        n_err++; $display("[TB] FAIL mul_cycle%0d: got ctl=%b busy=%0d expected ctl=%b busy=%0d", i, ctl(), busy, exp_ctl[i], exp_busy[i]);
      end
      tick();
    end
    is_mul_EX = 1'b0;
    #1;
    n_vec++;
    if (ctl() !== 8'b0000_0000 || busy !== 1'b0 || cycles !== 32'd3) begin
      n_err++; $display("[TB] FAIL mul_done: got ctl=%b busy=%0d cycles=%0d expected 0/0/3", ctl(), busy, cycles);
    end
    n_vec++;
    if (se_s !== 1'b0 || busy_s !== 1'b0) begin
      n_err++; $display("[TB] FAIL mul_lat1: got se=%0d busy=%0d expected 0/0", se_s, busy_s);
    end
  endtask

  task automatic test_miss_mid_mul();
    do_reset();
    is_mul_EX = 1'b1;
    tick();
    tick();
    mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (ctl() !== 8'b1111_0001 || busy !== 1'b1) begin
        n_err++; $display("[TB] FAIL miss_hold%0d: got ctl=%b busy=%0d expected %b/1", i, ctl(), busy, 8'b1111_0001);
      end
      tick();
    end
    mem_stall = 1'b0;
    #1;
    n_vec++;
    if (ctl() !== 8'b1110_0010) begin
      n_err++; $display("[TB] FAIL miss_release: got %b expected %b", ctl(), 8'b1110_0010);
    end
    tick();
    n_vec++;
    if (ctl() !== 8'b0000_0000 || busy !== 1'b1 || cycles !== 32'd8) begin
      n_err++; $display("[TB] FAIL miss_complete: got ctl=%b busy=%0d cycles=%0d expected 0/1/8", ctl(), busy, cycles);
    end
  endtask

  task automatic test_branch_under_miss();
    do_reset();
    pc_src = FROM_EX; mem_stall = 1'b1; is_mul_EX = 1'b1;
    #1;
    n_vec++;
    if (ctl() !== 8'b1111_0001) begin
      n_err++; $display("[TB] FAIL branch_miss: got %b expected %b", ctl(), 8'b1111_0001);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL mul_deferred: got busy=%0d expected 0", busy);
    end
    is_mul_EX = 1'b0; mem_stall = 1'b0;
    #1;
    n_vec++;
    if (ctl() !== 8'b0000_1100) begin
      n_err++; $display("[TB] FAIL branch_release: got %b expected %b", ctl(), 8'b0000_1100);
    end
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    is_mul_EX = 1'b1;
    tick();
    tick();
    is_mul_EX = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if (ctl() !== 8'b0000_0000 || busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_mid_mul: got ctl=%b busy=%0d expected 0/0", ctl(), busy);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    mem_stall = 1'b0;
    #1;
    n_vec++;
    if (cycles_s !== 4'd15) begin
      n_err++; $display("[TB] FAIL perf_saturate: got %0d expected 15", cycles_s);
    end
    n_vec++;
    if (cycles !== 32'd20) begin
      n_err++; $display("[TB] FAIL perf_count: got %0d expected 20", cycles);
    end
    tick();
    n_vec++;
    if (cycles_s !== 4'd15 || cycles !== 32'd20) begin
      n_err++; $display("[TB] FAIL perf_hold: got %0d/%0d expected 15/20", cycles_s, cycles);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_multiply();
    test_miss_mid_mul();
    test_branch_under_miss();
    test_reset_mid_mul();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
